// File: rtl/lcd_digit_display.sv
// HD44780 character-LCD writer: power-up init, then one digit per LCD_Enable rising edge at line-1 column Num.
// Optional macro LCD_CURSOR_EN: blinking cursor, re-placed on the written column after each write.
module lcd_digit_display #(
    parameter int PWRUP_CYC    = 750000,
    parameter int SETUP_CYC    = 4,
    parameter int E_HIGH_CYC   = 25,
    parameter int CMD_WAIT_CYC = 2500,
    parameter int CLR_WAIT_CYC = 100000
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       LCD_Enable,
    input  logic [1:0] Num,
    input  logic [3:0] LCD_Num,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       busy,
    output logic       init_done
);
    localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    // Counter only ever reaches CNT_MAX-1, so it never wraps.
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef LCD_CURSOR_EN
    localparam logic [7:0] DISP_CTRL = 8'h0F;
`else
    localparam logic [7:0] DISP_CTRL = 8'h0C;
`endif

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_CUR
    } state_t;
    typedef enum logic [1:0] {P_SETUP, P_EHIGH, P_WAIT} phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             en_q;
    logic             pend;
    logic [1:0]       pend_col, col;
    logic [3:0]       pend_val, val;
    logic             edge_det, service, sending, last_cyc, byte_done;
    logic [7:0]       cur_byte;
    logic             cur_rs;
    int               phase_len;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = DISP_CTRL;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    function automatic logic [7:0] ascii_of(input logic [3:0] v);
        ascii_of = (v < 4'd10) ? (8'h30 + {4'h0, v}) : 8'h2D;
    endfunction

    assign edge_det = LCD_Enable & ~en_q;
    // A fresh edge in IDLE reloads the slot first; service waits one cycle so the newest value wins.
    assign service  = (state == S_IDLE) & pend & ~edge_det;
    assign sending  = (state == S_INIT) | (state == S_WR_ADDR) |
                      (state == S_WR_DATA) | (state == S_WR_CUR);

    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        case (state)
            S_INIT:               cur_byte = init_byte(idx);
            S_WR_ADDR, S_WR_CUR:  cur_byte = 8'h80 | {6'b0, col};
            S_WR_DATA: begin
                cur_byte = ascii_of(val);
                cur_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        phase_len = SETUP_CYC;
        case (phase)
            P_EHIGH: phase_len = E_HIGH_CYC;
            P_WAIT:  phase_len = (state == S_INIT && idx == 3'd4) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
            default: phase_len = SETUP_CYC;
        endcase
    end

    assign last_cyc  = (cnt == CNT_W'(phase_len - 1));
    assign byte_done = sending & (phase == P_WAIT) & last_cyc;

    // State register and control-side bookkeeping
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWRUP;
            phase     <= P_SETUP;
            cnt       <= '0;
            idx       <= '0;
            en_q      <= 1'b0;
            pend      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            en_q  <= LCD_Enable;
            if (edge_det)
                pend <= 1'b1;
            else if (service)
                pend <= 1'b0;
            if (state == S_INIT && byte_done && idx == 3'd5)
                init_done <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (edge_det) begin
            pend_col <= Num;
            pend_val <= LCD_Num;
        end
        if (service) begin
            col <= pend_col;
            val <= pend_val;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        idx_n   = idx;
        case (state)
            S_PWRUP: begin
                if (cnt == CNT_W'(PWRUP_CYC - 1)) begin
                    state_n = S_INIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (service)
                    state_n = S_WR_ADDR;
            end
            default: begin
                if (!last_cyc) begin
                    cnt_n = cnt + CNT_W'(1);
                end else begin
                    cnt_n = '0;
                    case (phase)
                        P_SETUP: phase_n = P_EHIGH;
                        P_EHIGH: phase_n = P_WAIT;
                        default: begin
                            phase_n = P_SETUP;
                            case (state)
                                S_INIT: begin
                                    if (idx == 3'd5) begin
                                        state_n = S_IDLE;
                                        idx_n   = '0;
                                    end else begin
                                        idx_n = idx + 3'd1;
                                    end
                                end
                                S_WR_ADDR: state_n = S_WR_DATA;
`ifdef LCD_CURSOR_EN
                                S_WR_DATA: state_n = S_WR_CUR;
`else
                                S_WR_DATA: state_n = S_IDLE;
`endif
                                default:   state_n = S_IDLE;
                            endcase
                        end
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        lcd_rw = 1'b0;
        lcd_e  = sending & (phase == P_EHIGH);
        lcd_rs = sending & cur_rs;
        lcd_db = sending ? cur_byte : 8'h00;
        busy   = (state != S_IDLE) | pend;
    end
endmodule

// File: tb/tb_lcd_digit_display.sv
// Randomized scoreboard bench for lcd_digit_display: expected LCD byte stream is queued at stimulus time.
module tb_lcd_digit_display;
    localparam int PW = 20, SU = 1, EH = 2, CW = 5, CL = 10;
    localparam int BYTE_CYC = SU + EH + CW;
`ifdef LCD_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       LCD_Enable = 1'b0;
    logic [1:0] Num = 2'd0;
    logic [3:0] LCD_Num = 4'd0;
    logic       lcd_rs, lcd_rw, lcd_e, busy, init_done;
    logic [7:0] lcd_db;

    int vecs = 0;
    int errs = 0;
    logic [8:0] exp_q[$];

    lcd_digit_display #(
        .PWRUP_CYC(PW), .SETUP_CYC(SU), .E_HIGH_CYC(EH),
        .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL)
    ) dut (
        .sysclk(sysclk), .rst_n(rst_n), .LCD_Enable(LCD_Enable), .Num(Num),
        .LCD_Num(LCD_Num), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_db(lcd_db), .busy(busy), .init_done(init_done)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] ascii_of(input int v);
        return (v < 10) ? 8'(48 + v) : 8'h2D;
    endfunction

    task automatic expect_write(input int c, input int v);
        exp_q.push_back({1'b0, 8'(128 + c)});
        exp_q.push_back({1'b1, ascii_of(v)});
        if (CUR) exp_q.push_back({1'b0, 8'(128 + c)});
    endtask

    task automatic expect_init();
        int seq[6];
        seq = '{8'h38, 8'h38, 8'h38, (CUR ? 8'h0F : 8'h0C), 8'h01, 8'h06};
        foreach (seq[i]) exp_q.push_back({1'b0, 8'(seq[i])});
    endtask

    // Pulse held high for 'hold' cycles; inputs scrambled after the edge must be ignored.
    task automatic pulse(input int c, input int v, input int hold);
        @(negedge sysclk);
        LCD_Enable = 1'b1;
        Num = 2'(c);
        LCD_Num = 4'(v);
        for (int h = 1; h < hold; h++) begin
            @(negedge sysclk);
            Num = 2'($urandom_range(0, 3));
            LCD_Num = 4'($urandom_range(0, 15));
        end
        @(negedge sysclk);
        LCD_Enable = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= limit) chk("idle_timeout", 1, 0);
    endtask

    task automatic timed_write(input int c, input int v);
        int n = 0;
        expect_write(c, v);
        @(negedge sysclk);
        LCD_Enable = 1'b1;
        Num = 2'(c);
        LCD_Num = 4'(v);
        @(negedge sysclk);
        LCD_Enable = 1'b0;
        while (busy && n < 1000) begin
            n++;
            @(negedge sysclk);
        end
        chk("busy_cycles", n, 1 + (CUR ? 3 : 2) * BYTE_CYC);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every lcd_e rise presents one byte to the scoreboard.
    logic e_prev = 1'b0;
    int   hi = 0;
    initial begin : monitor
        logic [8:0] got;
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                e_prev = 1'b0;
                hi = 0;
            end else begin
                if (lcd_e && !e_prev) begin
                    got = {lcd_rs, lcd_db};
                    if (exp_q.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL unexpected_byte: got %0h, expected none", got);
                    end else begin
                        chk("byte", got, exp_q.pop_front());
                    end
                    chk("rw", lcd_rw, 0);
                    hi = 1;
                end else if (lcd_e) begin
                    hi++;
                end else if (e_prev) begin
                    chk("e_width", hi, EH);
                end
                e_prev = lcd_e;
            end
        end
    end

    initial begin : stim
        int n, np, c, v, lc, lv;
        repeat (3) @(negedge sysclk);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_db", lcd_db, 0);
        chk("rst_busy", busy, 1);
        chk("rst_init_done", init_done, 0);

        expect_init();
        expect_write(1, 5);
        rst_n = 1'b1;
        fork
            begin
                n = 0;
                do begin
                    @(posedge sysclk);
                    #1;
                    n++;
                end while (!lcd_e && n < 200);
                chk("first_e_latency", n, PW + SU);
            end
            begin
                repeat (5) @(negedge sysclk);
                pulse(1, 5, 1);
            end
        join
        wait_idle(2000);
        chk("init_done", init_done, 1);
        chk("idle_busy", busy, 0);

        timed_write(2, 7);
        timed_write(3, 12);

        expect_write(0, 3);
        expect_write(0, 9);
        pulse(0, 3, 1);
        pulse(0, 1, 1);
        pulse(0, 4, 1);
        pulse(0, 9, 1);
        wait_idle(2000);

        for (int it = 0; it < 12; it++) begin
            np = $urandom_range(1, 3);
            c = $urandom_range(0, 3);
            v = $urandom_range(0, 15);
            expect_write(c, v);
            pulse(c, v, $urandom_range(1, 4));
            for (int j = 1; j < np; j++) begin
                lc = $urandom_range(0, 3);
                lv = $urandom_range(0, 15);
                pulse(lc, lv, 1);
            end
            if (np > 1) expect_write(lc, lv);
            wait_idle(2000);
        end

        expect_write(2, 9);
        pulse(2, 9, 1);
        n = 0;
        while (!(lcd_e && lcd_rs) && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 100) chk("data_strobe_timeout", 1, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_e", lcd_e, 0);
        chk("abort_init_done", init_done, 0);
        chk("abort_busy", busy, 1);
        exp_q.delete();
        repeat (2) @(negedge sysclk);
        expect_init();
        rst_n = 1'b1;
        wait_idle(2000);
        chk("reinit_done", init_done, 1);
        timed_write($urandom_range(0, 3), $urandom_range(0, 15));
        chk("queue_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/lcd_digit_display.md
Name: lcd_digit_display

Overview:
- Character-LCD writer (HD44780-compatible, 8-bit bus, write-only) downstream of the five-key control system.
- Consumes the display strobe `LCD_Enable`, the position number `Num` and the digit `LCD_Num`.
- Runs the LCD power-up init sequence, then writes one ASCII character at line-1 column `Num` per accepted request.
- Holds at most one pending request while a write is in flight.

Parameters:
- PWRUP_CYC, 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- SETUP_CYC, 4: cycles RS/DB are stable before `lcd_e` rises.
- E_HIGH_CYC, 25: `lcd_e` high width in cycles.
- CMD_WAIT_CYC, 2500: wait after `lcd_e` falls, for all bytes except clear.
- CLR_WAIT_CYC, 100000: wait after the clear command (0x01).

Ports:
- sysclk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- LCD_Enable  in  1  display request; rising edge = request
- Num  in  2  column index 0..3
- LCD_Num  in  4  digit value
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0
- lcd_e  out  1  LCD enable strobe
- lcd_db  out  8  LCD data bus
- busy  out  1  1 while initialising, transferring, or a request is pending
- init_done  out  1  1 once the init sequence has completed

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, busy=1, init_done=0.
  - Internal state: edge register=0, pending flag cleared, FSM=PWRUP, counters=0.
  - Reset mid-transfer aborts immediately, drops `lcd_e` to 0, and restarts from PWRUP.
- Top FSM states: PWRUP -> INIT -> IDLE -> WR_ADDR -> WR_DATA [-> WR_CUR] -> IDLE.
- PWRUP: count PWRUP_CYC cycles, then go to INIT.
- INIT: send 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0.
  - 0x0C becomes 0x0F when the optional feature is compiled in.
  - The clear byte uses CLR_WAIT_CYC; all others use CMD_WAIT_CYC.
  - After the last byte: init_done=1 and go to IDLE.
- Byte-transfer sub-FSM, identical for every byte:
  - SETUP: drive RS/DB for SETUP_CYC cycles with lcd_e=0.
  - EHIGH: lcd_e=1 for E_HIGH_CYC cycles.
  - WAIT: lcd_e=0, DB held, for the wait count.
  - Then the byte is done.
  - Total byte time = SETUP_CYC + E_HIGH_CYC + wait cycles.
- Request capture:
  - Rising edge is detected as LCD_Enable=1 while the registered previous value=0.
  - `Num` and `LCD_Num` are sampled in that same cycle.
  - A level held high produces only one request.
  - Requests are captured in every state, including PWRUP and INIT, into a one-deep pending slot.
  - A newer request overwrites an unserviced pending one (last-wins).
- IDLE: if pending, clear the slot and latch col/val in the same cycle, then go to WR_ADDR.
- WR_ADDR: RS=0, DB = 0x80 + col.
- WR_DATA: RS=1, DB is the ASCII character:
  - val 0..9 -> 0x30 + val.
  - val 10..15 -> 0x2D ('-').
- A request arriving during WR_ADDR/WR_DATA does not alter the in-flight col/val. It becomes pending and is serviced right after return to IDLE, with no idle gap beyond one cycle.
- busy = (state != IDLE) | pending. It is registered, so busy rises the cycle after an edge seen in IDLE.
- Simultaneous edge and IDLE service in the same cycle: the new edge wins, because the slot is loaded with the new value and serviced next cycle.
- Counters must be wide enough for max(PWRUP_CYC, CLR_WAIT_CYC). No wrap is permitted.

Optional Feature:
- Macro: LCD_CURSOR_EN.
- Defined:
  - The init display-control byte is 0x0F (cursor on, blink).
  - After WR_DATA, an extra state WR_CUR sends RS=0, DB = 0x80 + col, so the blinking cursor sits on the just-written position.
- Undefined:
  - The init byte is 0x0C.
  - WR_CUR is absent and the FSM returns directly to IDLE after WR_DATA.

Test Plan (PWRUP_CYC=20, SETUP_CYC=1, E_HIGH_CYC=2, CMD_WAIT_CYC=5, CLR_WAIT_CYC=10):
- Reset release, no input -> first lcd_e rise 21 cycles after release. Six bytes 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all RS=0, each lcd_e high exactly 2 cycles; init_done=1, busy=0 after the last WAIT.
- After init, pulse LCD_Enable with Num=2, LCD_Num=7 -> bytes 0x82 (RS=0) then 0x37 (RS=1); busy high throughout, low after the final wait.
- Num=3, LCD_Num=12 -> bytes 0x83 then 0x2D.
- Three LCD_Enable pulses during the first write (values 1, 4, 9 at Num=0) -> after the current write, exactly one write 0x80/0x39; no writes for 1 or 4.
- LCD_Enable pulse during PWRUP (Num=1, LCD_Num=5) -> serviced right after init: 0x81, 0x35.
- rst_n low while lcd_e=1 during WR_DATA -> lcd_e=0 and init_done=0 immediately; the full init sequence repeats; with LCD_CURSOR_EN the init byte is 0x0F and each write is followed by 0x80+col.
